// File: rtl/delay_line_probe.sv
// ============================================================================
// Module      : delay_line_probe
// Description : Latency probe for a fixed-length delay line. Flushes the
//               path with zeros, launches a single marker word and counts
//               clock cycles until the marker comes back on echo_in. Reports
//               the latency or a timeout.
//               Optional macro AVG4_EN: average four back-to-back rounds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_line_probe #(
  parameter int                DATA_W     = 8,
  parameter int                CNT_W      = 8,
  parameter int                MAX_DELAY  = 127,
  parameter logic [DATA_W-1:0] PROBE_WORD = 8'hA5,
  parameter int                FLUSH_LEN  = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] echo_in,
  output logic [DATA_W-1:0] probe_out,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  latency
);

  localparam int                 FLUSH_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FLUSH_W-1:0] C_FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0]   C_MAX_CNT    = CNT_W'(MAX_DELAY);
  localparam logic [CNT_W-1:0]   C_ONE        = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [FLUSH_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_latency;
  logic                r_done;
  logic                r_timeout;
  logic [DATA_W-1:0]   w_probe;
  logic                w_match;
  logic                w_hit;        // marker returned in this cycle
  logic                w_expire;     // last counter value passed without a match
  logic                w_last_round; // a hit now ends the whole measurement
  logic                w_finish;     // result becomes valid at the next edge
  logic [CNT_W-1:0]    w_result;

`ifdef AVG4_EN
  logic [1:0]          r_round;
  logic [CNT_W+1:0]    r_acc;
  logic [CNT_W+1:0]    w_acc_sum;

  assign w_acc_sum    = r_acc + {2'b00, r_cnt};
  assign w_last_round = (r_round == 2'd3);
  // Floor average of the four counts; a timeout overrides with all-ones
  assign w_result     = w_expire ? '1 : w_acc_sum[CNT_W+1:2];

  // Round index and running sum, restarted whenever the probe is idle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_round <= 2'd0;
      r_acc   <= '0;
    end else if (r_state == S_IDLE) begin
      r_round <= 2'd0;
      r_acc   <= '0;
    end else if (w_hit) begin
      r_round <= r_round + 2'd1;
      r_acc   <= w_acc_sum;
    end
  end
`else
  assign w_last_round = 1'b1;
  assign w_result     = w_expire ? '1 : r_cnt;
`endif

  assign w_finish = (w_hit & w_last_round) | w_expire;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and marker drive
  always_comb begin
    w_next_state = r_state;
    w_probe      = '0;
    w_match      = (echo_in == PROBE_WORD);
    w_hit        = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == C_FLUSH_LAST) begin
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        // Counter is zero here, so a same-cycle echo reports latency 0
        w_probe = PROBE_WORD;
        if (w_match) begin
          w_hit        = 1'b1;
          w_next_state = w_last_round ? S_DONE : S_FLUSH;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // A match on the final counter value still counts as a match
        if (w_match) begin
          w_hit        = 1'b1;
          w_next_state = w_last_round ? S_DONE : S_FLUSH;
        end else if (r_cnt == C_MAX_CNT) begin
          w_expire     = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Flush length counter and saturating latency counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_flush_cnt <= '0;
      r_cnt       <= '0;
    end else begin
      r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 1'b1 : '0;
      case (r_state)
        S_SEND:  r_cnt <= C_ONE;
        S_WAIT:  r_cnt <= (r_cnt == C_MAX_CNT) ? r_cnt : r_cnt + C_ONE;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Registered result and the done/timeout pulses aligned with it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_latency <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= w_finish;
      r_timeout <= w_expire;
      if (w_finish) begin
        r_latency <= w_result;
      end
    end
  end

  assign probe_out = w_probe;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign latency   = r_latency;

endmodule

`default_nettype wire
